// File: rtl/sysbus_mem_responder_if.sv
// System-bus request/response channel between an initiator and a memory responder.
// The initiator drives the master side and the responder drives the slave side.
interface sysbus_mem_responder_if #(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 13
);
    logic                 reqcyc;
    logic [WIDTH-1:0]     req;
    logic [TAG_WIDTH-1:0] reqtag;
    logic                 reqack;
    logic                 respcyc;
    logic [WIDTH-1:0]     resp;
    logic [TAG_WIDTH-1:0] resptag;
    logic                 respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Line-granular memory responder: 8-beat write bursts into a line store, and 8-beat read
// bursts with a fixed initial latency and per-beat response backpressure.
module sysbus_mem_responder #(
    parameter int WIDTH      = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int MEM_LINES  = 256,
    parameter int RD_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sysbus_mem_responder_if.slave    bus
);
    localparam int READ_BIT = 12;
    localparam int LW       = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int LAT_EFF  = (RD_LATENCY < 1) ? 1 : RD_LATENCY;
    localparam int LATW     = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_DATA  = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_BURST = 2'd3;

    logic [1:0]           state;
    logic [LW-1:0]        line_q;
    logic [2:0]           beat_q;
    logic [2:0]           nxt_beat;
    logic [LATW-1:0]      lat_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 respcyc_q;
    logic [WIDTH-1:0]     resp_q;
    logic [TAG_WIDTH-1:0] resptag_q;
    logic [LW-1:0]        req_line;
    logic                 wr_en;

    logic [WIDTH-1:0] mem [0:MEM_LINES*8-1];

    // Byte offset within the 64-byte line is dropped; upper address bits alias.
    assign req_line = LW'((bus.req >> 6) % WIDTH'(MEM_LINES));
    assign nxt_beat = beat_q + 3'd1;

    assign bus.reqack  = bus.reqcyc && (state == IDLE || state == WR_DATA);
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;
    assign bus.resptag = resptag_q;

    assign wr_en = reset_n && bus.reqcyc && (state == WR_DATA);

    // Backing store is never reset so partially written lines survive an abort.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{line_q, beat_q}] <= bus.req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            line_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            tag_q     <= '0;
            respcyc_q <= 1'b0;
            resp_q    <= '1;
            resptag_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.reqcyc) begin
                        line_q <= req_line;
                        tag_q  <= bus.reqtag;
                        beat_q <= '0;
                        if (bus.reqtag[READ_BIT]) begin
                            state <= RD_WAIT;
                            lat_q <= LATW'(LAT_EFF - 1);
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.reqcyc) begin
                        beat_q <= nxt_beat;
                        if (beat_q == 3'd7)
                            state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (lat_q == '0) begin
                        state     <= RD_BURST;
                        beat_q    <= '0;
                        respcyc_q <= 1'b1;
                        resp_q    <= mem[{line_q, 3'd0}];
                        resptag_q <= tag_q;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                RD_BURST: begin
                    // Without respack the current beat simply stays registered on the bus.
                    if (bus.respack) begin
                        if (beat_q == 3'd7) begin
                            state     <= IDLE;
                            beat_q    <= '0;
                            respcyc_q <= 1'b0;
                            resp_q    <= '1;
                        end else begin
                            beat_q <= nxt_beat;
                            resp_q <= mem[{line_q, nxt_beat}];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line writes, read latency and ordering,
// response stalls, busy-time request blocking, mid-write reset and address aliasing.
module tb_sysbus_mem_responder;
    localparam int W = 64;
    localparam int T = 13;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sysbus_mem_responder_if #(.WIDTH(W), .TAG_WIDTH(T)) bus();

    sysbus_mem_responder #(
        .WIDTH(W), .TAG_WIDTH(T), .MEM_LINES(256), .RD_LATENCY(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] dat [8];
    logic [W-1:0] ones;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [W-1:0] base, input logic [W-1:0] stp);
        for (int i = 0; i < 8; i++) dat[i] = base + stp * W'(i);
    endtask

    task automatic wr_line(input logic [W-1:0] addr, input logic [T-1:0] tag);
        int acks;
        int rc;
        acks = 0;
        rc = 0;
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        #1;
        if (bus.reqack) acks++;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.req = dat[i];
            #1;
            if (bus.reqack) acks++;
            if (bus.respcyc) rc++;
            tick();
        end
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        #1;
        if (bus.respcyc) rc++;
        chk("wr_acks", W'(acks), W'(9));
        chk("wr_no_respcyc", W'(rc), W'(0));
    endtask

    task automatic rd_line(input logic [W-1:0] addr, input logic [T-1:0] tag,
                           input int stall_beat, input int stall_len, input bit hold,
                           input logic [W-1:0] nxt_addr, input logic [T-1:0] nxt_tag);
        int lat;
        int bad;
        lat = 0;
        bad = 0;
        bus.reqcyc  = 1'b1;
        bus.req     = addr;
        bus.reqtag  = tag;
        bus.respack = 1'b1;
        #1;
        chk("rd_accept", W'(bus.reqack), W'(1));
        tick();
        if (hold) begin
            bus.req    = nxt_addr;
            bus.reqtag = nxt_tag;
        end else begin
            bus.reqcyc = 1'b0;
        end
        #1;
        while (!bus.respcyc && lat < 50) begin
            if (hold && bus.reqack) bad++;
            tick();
            lat++;
        end
        chk("rd_latency", W'(lat), W'(4));
        for (int b = 0; b < 8; b++) begin
            chk("rd_respcyc", W'(bus.respcyc), W'(1));
            chk("rd_data", bus.resp, dat[b]);
            chk("rd_tag", W'(bus.resptag), W'(tag));
            if (b == stall_beat) begin
                bus.respack = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    if (hold && bus.reqack) bad++;
                    tick();
                    chk("rd_stall_hold", bus.resp, dat[b]);
                    chk("rd_stall_cyc", W'(bus.respcyc), W'(1));
                end
                bus.respack = 1'b1;
                #1;
            end
            if (hold && bus.reqack) bad++;
            tick();
        end
        chk("rd_done_respcyc", W'(bus.respcyc), W'(0));
        chk("rd_done_resp", bus.resp, ones);
        if (hold) begin
            chk("rd_busy_blocked", W'(bad), W'(0));
            chk("rd_idle_reack", W'(bus.reqack), W'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ones = '1;
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        chk("rst_respcyc", W'(bus.respcyc), W'(0));
        chk("rst_resp", bus.resp, ones);
        chk("rst_resptag", W'(bus.resptag), W'(0));
        chk("rst_reqack", W'(bus.reqack), W'(0));
        reset_n = 1'b1;
        tick();

        // Basic line write and in-order read.
        fill(W'(64'h11), W'(64'h11));
        wr_line(W'(64'h1000), T'(13'h0000));
        rd_line(W'(64'h1000), T'(13'h1005), -1, 0, 1'b0, '0, '0);

        // Response stall on beat 3.
        rd_line(W'(64'h1000), T'(13'h1006), 3, 5, 1'b0, '0, '0);

        // Next request held during the whole read, accepted as IDLE returns.
        rd_line(W'(64'h1000), T'(13'h1007), -1, 0, 1'b1, W'(64'h2000), T'(13'h0007));
        fill(W'(64'h0101_0000), W'(64'h10));
        wr_line(W'(64'h2000), T'(13'h0007));
        rd_line(W'(64'h2000), T'(13'h1008), -1, 0, 1'b0, '0, '0);

        // Reset after four write beats; words 4-7 keep the older contents.
        fill(W'(64'hA1), W'(64'h1));
        bus.reqcyc = 1'b1;
        bus.req    = W'(64'h1000);
        bus.reqtag = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.req = dat[i];
            tick();
        end
        reset_n    = 1'b0;
        bus.reqcyc = 1'b0;
        tick();
        chk("mid_rst_respcyc", W'(bus.respcyc), W'(0));
        chk("mid_rst_resp", bus.resp, ones);
        chk("mid_rst_resptag", W'(bus.resptag), W'(0));
        reset_n = 1'b1;
        tick();
        for (int i = 4; i < 8; i++) dat[i] = W'(64'h11) * W'(i + 1);
        rd_line(W'(64'h1000), T'(13'h1009), -1, 0, 1'b0, '0, '0);

        // Address aliasing: high bits wrap modulo the line count; low 6 bits ignored.
        fill(W'(64'hDEAD_0000), W'(64'h1));
        wr_line(W'(64'h3F_FFC0), T'(13'h0000));
        rd_line(W'(64'h3FC0), T'(13'h1000), -1, 0, 1'b0, '0, '0);
        fill(W'(64'hBEEF_0000), W'(64'h3));
        wr_line(W'(64'h7F), T'(13'h0000));
        rd_line(W'(64'h40), T'(13'h10AA), -1, 0, 1'b0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
